// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state types shared by the sequential ALU
package alu_seq_pkg;

  typedef enum logic [3:0] {
    kADD  = 4'd0,
    kSUB  = 4'd1,
    kXOR  = 4'd2,
    kAND  = 4'd3,
    kRXOR = 4'd4,
    kRSH  = 4'd5,
    kSEQ  = 4'd6,
    kSLT  = 4'd7,
    kMUL  = 4'd8
  } op_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - single-cycle ALU ops and carry/borrow
module alu_comb_core
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  op_mne        i_op,
  output logic [W-1:0] o_result,
  output logic         o_carry
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the unsigned borrow (A < B).
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      kADD: begin
        o_result = w_sum[W-1:0];
        o_carry  = w_sum[W];
      end
      kSUB: begin
        o_result = w_diff[W-1:0];
        o_carry  = w_diff[W];
      end
      kXOR:    o_result = i_a ^ i_b;
      kAND:    o_result = i_a & i_b;
      kRXOR:   o_result = {{(W-1){1'b0}}, ^i_a};
      kRSH:    o_result = i_a;
      kSEQ:    o_result = {{(W-1){1'b0}}, (i_a == i_b)};
      kSLT:    o_result = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative right shift and shift-add multiply
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic [3:0]   OP,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] Out,
  output logic         Zero,
  output logic         Carry,
  output logic         Busy
);

  localparam int CW = SHW + 1;

  alu_state_t     r_state, w_state_nxt;
  logic [W-1:0]   r_out, w_out_nxt;
  logic           r_zero, w_zero_nxt;
  logic           r_carry, w_carry_nxt;
  logic [W-1:0]   r_acc, w_acc_nxt;
  logic [W-1:0]   r_mcand, w_mcand_nxt;
  logic [W-1:0]   r_mplier, w_mplier_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_is_mul, w_is_mul_nxt;

  logic           w_accept;
  op_mne          w_op;
  logic [SHW-1:0] w_shamt;
  logic [W-1:0]   w_core_res;
  logic           w_core_carry;
  logic [W-1:0]   w_step;

  assign w_op     = op_mne'(OP);
  assign w_shamt  = InputB[SHW-1:0];
  assign InReady  = (r_state == IDLE) || ((r_state == DONE) && OutReady);
  assign w_accept = InValid && InReady;
  assign OutValid = (r_state == DONE);
  assign Busy     = (r_state == BUSY);
  assign Out      = r_out;
  assign Zero     = r_zero;
  assign Carry    = r_carry;

  alu_comb_core #(.W(W)) u_core (
    .i_a      (InputA),
    .i_b      (InputB),
    .i_op     (w_op),
    .o_result (w_core_res),
    .o_carry  (w_core_carry)
  );

  // One engine iteration: shift-add step for multiply, 1-bit logical shift otherwise.
  assign w_step = r_is_mul ? (r_mplier[0] ? r_acc + r_mcand : r_acc) : (r_acc >> 1);

  always_comb begin
    w_state_nxt  = r_state;
    w_out_nxt    = r_out;
    w_zero_nxt   = r_zero;
    w_carry_nxt  = r_carry;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_is_mul_nxt = r_is_mul;

    case (r_state)
      BUSY: begin
        w_acc_nxt    = w_step;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DONE;
          w_out_nxt   = w_step;
          w_zero_nxt  = (w_step == '0);
          w_carry_nxt = 1'b0;
        end
      end
      DONE:    if (OutReady) w_state_nxt = IDLE;
      default: ;
    endcase

    // A transfer in IDLE or DONE always starts the new op; it overrides DONE->IDLE.
    if (w_accept) begin
      if (w_op == kMUL) begin
        w_state_nxt  = BUSY;
        w_acc_nxt    = '0;
        w_mcand_nxt  = InputA;
        w_mplier_nxt = InputB;
        w_cnt_nxt    = CW'(W);
        w_is_mul_nxt = 1'b1;
      end else if ((w_op == kRSH) && (w_shamt != '0)) begin
        w_state_nxt  = BUSY;
        w_acc_nxt    = InputA;
        w_cnt_nxt    = {1'b0, w_shamt};
        w_is_mul_nxt = 1'b0;
      end else begin
        w_state_nxt = DONE;
        w_out_nxt   = w_core_res;
        w_zero_nxt  = (w_core_res == '0);
        w_carry_nxt = w_core_carry;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_out    <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_zero   <= w_zero_nxt;
      r_carry  <= w_carry_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_is_mul <= w_is_mul_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at W=8 and W=16
module tb_alu_seq;

  logic        Clk;
  logic        Reset_n;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, carry8, busy8;
  logic [7:0]  a8, b8, out8;
  logic [3:0]  op8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16, carry16, busy16;
  logic [15:0] a16, b16, out16;
  logic [3:0]  op16;

  int total;
  int bad;

  alu_seq #(.W(8)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n),
    .InValid(in_valid8), .InReady(in_ready8),
    .InputA(a8), .InputB(b8), .OP(op8),
    .OutValid(out_valid8), .OutReady(out_ready8),
    .Out(out8), .Zero(zero8), .Carry(carry8), .Busy(busy8)
  );

  alu_seq #(.W(16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n),
    .InValid(in_valid16), .InReady(in_ready16),
    .InputA(a16), .InputB(b16), .OP(op16),
    .OutValid(out_valid16), .OutReady(out_ready16),
    .Out(out16), .Zero(zero16), .Carry(carry16), .Busy(busy16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op on the W=8 DUT, wait for the result, check it, then consume it.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] op, input logic [7:0] eo, input logic ez,
                      input logic ec, input int elat, input int ebusy);
    int lat;
    int nbusy;
    @(negedge Clk);
    a8 = a; b8 = b; op8 = op; in_valid8 = 1'b1; out_ready8 = 1'b0;
    chk({tag, ".inready"}, 16'(in_ready8), 16'd1);
    @(posedge Clk);
    @(negedge Clk);
    in_valid8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    lat = 1;
    nbusy = 0;
    while (!out_valid8 && lat < 100) begin
      if (busy8 && !in_ready8) nbusy++;
      @(negedge Clk);
      lat++;
    end
    chk({tag, ".latency"}, 16'(lat), 16'(elat));
    chk({tag, ".busy_cycles"}, 16'(nbusy), 16'(ebusy));
    chk({tag, ".out"}, 16'(out8), 16'(eo));
    chk({tag, ".zero"}, 16'(zero8), 16'(ez));
    chk({tag, ".carry"}, 16'(carry8), 16'(ec));
    out_ready8 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready8 = 1'b0;
    chk({tag, ".outvalid_drop"}, 16'(out_valid8), 16'd0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [15:0] eo, input logic ez,
                       input logic ec, input int elat);
    int lat;
    @(negedge Clk);
    a16 = a; b16 = b; op16 = op; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    chk({tag, ".latency"}, 16'(lat), 16'(elat));
    chk({tag, ".out"}, out16, eo);
    chk({tag, ".zero"}, 16'(zero16), 16'(ez));
    chk({tag, ".carry"}, 16'(carry16), 16'(ec));
    out_ready16 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    out_ready16 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;

    #2;
    chk("reset.outvalid", 16'(out_valid8), 16'd0);
    chk("reset.out", 16'(out8), 16'd0);
    chk("reset.zero", 16'(zero8), 16'd0);
    chk("reset.carry", 16'(carry8), 16'd0);
    chk("reset.busy", 16'(busy8), 16'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    //   tag          A      B      OP     Out    Z     C     lat busy
    run8("add",      8'hF0, 8'h20, 4'h0, 8'h10, 1'b0, 1'b1, 1, 0);
    run8("sub",      8'h03, 8'h05, 4'h1, 8'hFE, 1'b0, 1'b1, 1, 0);
    run8("xor",      8'h0F, 8'h3C, 4'h2, 8'h33, 1'b0, 1'b0, 1, 0);
    run8("and",      8'hF0, 8'h0F, 4'h3, 8'h00, 1'b1, 1'b0, 1, 0);
    run8("slt_neg",  8'hFE, 8'h01, 4'h7, 8'h01, 1'b0, 1'b0, 1, 0);
    run8("slt_pos",  8'h05, 8'h03, 4'h7, 8'h00, 1'b1, 1'b0, 1, 0);
    run8("slt_ovf",  8'h80, 8'h7F, 4'h7, 8'h01, 1'b0, 1'b0, 1, 0);
    run8("seq",      8'h07, 8'h07, 4'h6, 8'h01, 1'b0, 1'b0, 1, 0);
    run8("rxor",     8'h07, 8'h00, 4'h4, 8'h01, 1'b0, 1'b0, 1, 0);
    run8("undef",    8'h12, 8'h34, 4'hF, 8'h00, 1'b1, 1'b0, 1, 0);
    run8("mul",      8'h0D, 8'h0B, 4'h8, 8'h8F, 1'b0, 1'b0, 9, 8);
    run8("mul_wrap", 8'h10, 8'h10, 4'h8, 8'h00, 1'b1, 1'b0, 9, 8);
    run8("rsh3",     8'hB4, 8'h03, 4'h5, 8'h16, 1'b0, 1'b0, 4, 3);
    run8("rsh0",     8'hB4, 8'h00, 4'h5, 8'hB4, 1'b0, 1'b0, 1, 0);
    run8("rsh_lowb", 8'hB4, 8'h0B, 4'h5, 8'h16, 1'b0, 1'b0, 4, 3);

    // Back-pressure: result held while OutReady low, then back-to-back issue.
    @(negedge Clk);
    a8 = 8'h01; b8 = 8'h02; op8 = 4'h0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    in_valid8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.outvalid", 16'(out_valid8), 16'd1);
      chk("bp.out", 16'(out8), 16'h03);
      chk("bp.inready", 16'(in_ready8), 16'd0);
      @(negedge Clk);
    end
    a8 = 8'hAA; b8 = 8'hFF; op8 = 4'h2; in_valid8 = 1'b1; out_ready8 = 1'b1;
    #1;
    chk("b2b.inready", 16'(in_ready8), 16'd1);
    @(posedge Clk);
    @(negedge Clk);
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    chk("b2b.outvalid", 16'(out_valid8), 16'd1);
    chk("b2b.out", 16'(out8), 16'h55);
    out_ready8 = 1'b1;
    @(negedge Clk);
    out_ready8 = 1'b0;

    // Reset mid-multiply: everything cleared asynchronously, no transfer while low.
    @(negedge Clk);
    a8 = 8'h0D; b8 = 8'h0B; op8 = 4'h8; in_valid8 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    in_valid8 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("mid.busy_before", 16'(busy8), 16'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst.outvalid", 16'(out_valid8), 16'd0);
    chk("rst.out", 16'(out8), 16'h00);
    chk("rst.busy", 16'(busy8), 16'd0);
    in_valid8 = 1'b1; a8 = 8'h44; b8 = 8'h11; op8 = 4'h0;
    @(posedge Clk);
    @(negedge Clk);
    chk("rst.no_transfer", 16'(out_valid8), 16'd0);
    in_valid8 = 1'b0;
    Reset_n = 1'b1;
    run8("post_rst_add", 8'h01, 8'h01, 4'h0, 8'h02, 1'b0, 1'b0, 1, 0);

    run16("w16.add", 16'hF000, 16'h2000, 4'h0, 16'h1000, 1'b0, 1'b1, 1);
    run16("w16.mul", 16'h0D0D, 16'h000B, 4'h8, 16'h8F8F, 1'b0, 1'b0, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
